seq_monitor: RTL and testbench

Sequence monitor that sits directly downstream of the 3-bit walking sequence counter and consumes its output. Checks every valid sample against the fixed counter cycle 000→001→011→101→111→010→000, flags out-of-sequence values, counts completed cycles and errors. Gives the counter stage a self-check point and drives status to the board-level LEDs.

---
 rtl/seq_monitor_pkg.sv | 23 ++
 rtl/seq_monitor_succ.sv | 27 ++
 rtl/seq_monitor.sv | 124 ++++++++++++
 tb/tb_seq_monitor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seq_monitor_pkg.sv
// Shared definitions for the walking-sequence monitor: FSM encoding,
// cycle anchor codes and the six legal counter codes.
package seq_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    FAULT = 2'b10
  } state_t;

  // Cycle order: 000 -> 001 -> 011 -> 101 -> 111 -> 010 -> 000
  localparam logic [2:0] CODE_0 = 3'b000;
  localparam logic [2:0] CODE_1 = 3'b001;
  localparam logic [2:0] CODE_2 = 3'b011;
  localparam logic [2:0] CODE_3 = 3'b101;
  localparam logic [2:0] CODE_4 = 3'b111;
  localparam logic [2:0] CODE_5 = 3'b010;

  // First code of a cycle and the code that wraps back to it
  localparam logic [2:0] SEQ_START = CODE_0;
  localparam logic [2:0] SEQ_WRAP  = CODE_5;

endpackage

// File: rtl/seq_monitor_succ.sv
// seq_succ: combinational map from a counter code to its successor in the
// walking cycle, plus a flag marking the code as one of the six legal ones.
// Illegal codes (100, 110) report successor 000 with legal low.
module seq_succ
  import seq_monitor_pkg::*;
(
  input  logic [2:0] code_i,
  output logic [2:0] succ_o,
  output logic       legal_o
);

  // Successor lookup and legality decode
  always_comb begin
    succ_o  = SEQ_START;
    legal_o = 1'b1;
    case (code_i)
      CODE_0:  succ_o = CODE_1;
      CODE_1:  succ_o = CODE_2;
      CODE_2:  succ_o = CODE_3;
      CODE_3:  succ_o = CODE_4;
      CODE_4:  succ_o = CODE_5;
      CODE_5:  succ_o = CODE_0;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seq_monitor.sv
// seq_monitor: checks valid samples from the 3-bit walking counter against
// its fixed cycle, counts completed cycles and violations.
// Optional macro SEQ_MONITOR_RESYNC_EN: when defined, a valid 000 sample
// pulls the monitor out of FAULT back into TRACK; otherwise FAULT is sticky
// until reset.
module seq_monitor
  import seq_monitor_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       code,
  output logic             locked,
  output logic             err,
  output logic [2:0]       last,
  output logic [CNT_W-1:0] loop_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  state_t           state_q, state_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [2:0]       last_q, last_d;
  logic [CNT_W-1:0] loop_q, loop_d;
  logic [CNT_W-1:0] errc_q, errc_d;

  logic [2:0] code_succ_unused;
  logic       code_legal;
  logic [2:0] last_succ;
  logic       last_legal_unused;

  // Legality of the incoming code
  seq_succ u_code_chk (
    .code_i  (code),
    .succ_o  (code_succ_unused),
    .legal_o (code_legal)
  );

  // Expected next code given the last accepted one
  seq_succ u_last_succ (
    .code_i  (last_q),
    .succ_o  (last_succ),
    .legal_o (last_legal_unused)
  );

  // Saturating error counter increment
  logic [CNT_W-1:0] errc_inc;
  assign errc_inc = (errc_q == {CNT_W{1'b1}}) ? errc_q : errc_q + 1'b1;

  // Next-state and output decode; err drops whenever no violation is seen
  always_comb begin
    state_d  = state_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    last_d   = last_q;
    loop_d   = loop_q;
    errc_d   = errc_q;
    if (in_valid) begin
      case (state_q)
        IDLE: begin
          if (code_legal) begin
            state_d  = TRACK;
            last_d   = code;
            locked_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            errc_d = errc_inc;
          end
        end
        TRACK: begin
          if (code == last_succ) begin
            last_d = code;
            if (code == SEQ_START) loop_d = loop_q + 1'b1;
          end else begin
            err_d    = 1'b1;
            errc_d   = errc_inc;
            locked_d = 1'b0;
            state_d  = FAULT;
          end
        end
        FAULT: begin
`ifdef SEQ_MONITOR_RESYNC_EN
          if (code == SEQ_START) begin
            state_d  = TRACK;
            last_d   = SEQ_START;
            locked_d = 1'b1;
          end
`else
          state_d = FAULT;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      last_q   <= SEQ_START;
      loop_q   <= '0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      last_q   <= last_d;
      loop_q   <= loop_d;
      errc_q   <= errc_d;
    end
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign last     = last_q;
  assign loop_cnt = loop_q;
  assign err_cnt  = errc_q;

endmodule

// File: tb/tb_seq_monitor.sv
// Directed bench for seq_monitor. Two instances share stimulus: one at the
// default CNT_W=8 and one at CNT_W=2 for counter wrap/saturation.
module tb_seq_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] code = 3'b100;

  logic       locked8, err8, locked2, err2;
  logic [2:0] last8, last2;
  logic [7:0] loop8, errc8;
  logic [1:0] loop2, errc2;

  int vecs = 0;
  int miscmp = 0;

  always #5 clk = ~clk;

  seq_monitor #(.CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .code(code),
    .locked(locked8), .err(err8), .last(last8), .loop_cnt(loop8), .err_cnt(errc8)
  );

  seq_monitor #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .code(code),
    .locked(locked2), .err(err2), .last(last2), .loop_cnt(loop2), .err_cnt(errc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are checked there too.
  task automatic smp(input logic [2:0] c);
    in_valid = 1'b1;
    code     = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    code     = 3'b100;
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #4;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [2:0] cyc [6];

  initial begin
    cyc[0] = 3'b001; cyc[1] = 3'b011; cyc[2] = 3'b101;
    cyc[3] = 3'b111; cyc[4] = 3'b010; cyc[5] = 3'b000;

    // Reset state
    #12;
    chk("rst_locked", {31'd0, locked8}, 32'd0);
    chk("rst_err",    {31'd0, err8},    32'd0);
    chk("rst_last",   {29'd0, last8},   32'd0);
    chk("rst_loop",   {24'd0, loop8},   32'd0);
    chk("rst_errc",   {24'd0, errc8},   32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Full legal cycle; entry at 000 does not count a loop
    smp(3'b000);
    chk("entry_locked", {31'd0, locked8}, 32'd1);
    chk("entry_loop",   {24'd0, loop8},   32'd0);
    for (int i = 0; i < 6; i++) begin
      smp(cyc[i]);
      chk("cyc_err", {31'd0, err8}, 32'd0);
    end
    chk("cyc_loop",   {24'd0, loop8},   32'd1);
    chk("cyc_last",   {29'd0, last8},   32'd0);
    chk("cyc_locked", {31'd0, locked8}, 32'd1);

    // Out-of-sequence 111 after 011
    smp(3'b001);
    smp(3'b011);
    smp(3'b111);
    chk("viol_err",    {31'd0, err8},    32'd1);
    chk("viol_errc",   {24'd0, errc8},   32'd1);
    chk("viol_locked", {31'd0, locked8}, 32'd0);
    chk("viol_last",   {29'd0, last8},   32'd3);
    idle_cyc(1);
    chk("viol_pulse1", {31'd0, err8}, 32'd0);
    smp(3'b101);
    chk("fault_err", {31'd0, err8}, 32'd0);
    chk("fault_101_locked", {31'd0, locked8}, 32'd0);
    smp(3'b000);
    chk("fault_000_errc", {24'd0, errc8}, 32'd1);
    chk("fault_000_loop", {24'd0, loop8}, 32'd1);
    chk("fault_000_err",  {31'd0, err8},  32'd0);
`ifdef SEQ_MONITOR_RESYNC_EN
    chk("resync_locked", {31'd0, locked8}, 32'd1);
    chk("resync_last",   {29'd0, last8},   32'd0);
    smp(3'b001);
    chk("resync_next_last",   {29'd0, last8},   32'd1);
    chk("resync_next_locked", {31'd0, locked8}, 32'd1);
    chk("resync_next_err",    {31'd0, err8},    32'd0);
`else
    chk("sticky_locked", {31'd0, locked8}, 32'd0);
    chk("sticky_last",   {29'd0, last8},   32'd3);
    smp(3'b001);
    chk("sticky_next_locked", {31'd0, locked8}, 32'd0);
    chk("sticky_next_errc",   {24'd0, errc8},   32'd1);
`endif

    // Illegal codes in IDLE give back-to-back pulses, then lock on 001
    do_reset();
    smp(3'b100);
    chk("idle_err1",  {31'd0, err8},  32'd1);
    chk("idle_errc1", {24'd0, errc8}, 32'd1);
    smp(3'b110);
    chk("idle_err2",  {31'd0, err8},  32'd1);
    chk("idle_errc2", {24'd0, errc8}, 32'd2);
    chk("idle_locked0", {31'd0, locked8}, 32'd0);
    smp(3'b001);
    chk("idle_err3",   {31'd0, err8},    32'd0);
    chk("idle_locked", {31'd0, locked8}, 32'd1);
    chk("idle_last",   {29'd0, last8},   32'd1);

    // Gap in valid does not break tracking (invalid code driven meanwhile)
    idle_cyc(3);
    chk("gap_last", {29'd0, last8}, 32'd1);
    smp(3'b011);
    chk("gap_last2",  {29'd0, last8},   32'd3);
    chk("gap_locked", {31'd0, locked8}, 32'd1);
    chk("gap_err",    {31'd0, err8},    32'd0);

    // Repeat of last is a violation
    smp(3'b011);
    chk("rep_err",  {31'd0, err8},  32'd1);
    chk("rep_errc", {24'd0, errc8}, 32'd3);

    // Five full cycles: loop_cnt wraps at CNT_W=2
    do_reset();
    smp(3'b000);
    for (int n = 0; n < 5; n++)
      for (int i = 0; i < 6; i++) smp(cyc[i]);
    chk("wrap_loop8", {24'd0, loop8}, 32'd5);
    chk("wrap_loop2", {30'd0, loop2}, 32'd1);

    // Four violations in IDLE: err_cnt saturates at 3 for CNT_W=2
    do_reset();
    for (int i = 0; i < 4; i++) smp((i % 2 == 0) ? 3'b100 : 3'b110);
    chk("sat_errc2", {30'd0, errc2}, 32'd3);
    chk("sat_errc8", {24'd0, errc8}, 32'd4);
    chk("sat_err2",  {31'd0, err2},  32'd1);

    // Async reset between edges clears everything immediately
    smp(3'b000);
    smp(3'b001);
    chk("pre_async_locked", {31'd0, locked2}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_locked", {31'd0, locked2}, 32'd0);
    chk("async_last",   {29'd0, last8},   32'd0);
    chk("async_errc",   {30'd0, errc2},   32'd0);
    chk("async_errc8",  {24'd0, errc8},   32'd0);
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    smp(3'b110);
    chk("post_async_idle_err", {31'd0, err8}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
